// File: rtl/systolic_feeder.sv
// Feeder for a weight-stationary systolic array: loads N column weight vectors, streams
// diagonally skewed activation vectors, then drains the skew. Optional: SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    vec_count,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [N*DATA_W-1:0] w_data,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [N*DATA_W-1:0] d_data,
    output logic [N-1:0]        load_weights,
    output logic [N*DATA_W-1:0] weights_out,
    output logic [N*DATA_W-1:0] data_out,
    output logic [N-1:0]        valid_out,
    output logic                busy,
    output logic                done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cycles
`endif
);
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, FLUSH} state_t;

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [N-1:0]        load_reg, load_next;
    logic [N*DATA_W-1:0] wout_reg, wout_next;
    logic                done_reg, done_next;
    logic                d_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            cnt_reg   <= '0;
            load_reg  <= '0;
            wout_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            cnt_reg   <= cnt_next;
            load_reg  <= load_next;
            wout_reg  <= wout_next;
            done_reg  <= done_next;
        end
    end

    // col_reg indexes the weight column in LOAD_W and counts drain cycles in FLUSH
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        cnt_next   = cnt_reg;
        load_next  = '0;
        wout_next  = wout_reg;
        done_next  = 1'b0;
        w_ready    = 1'b0;
        d_ready    = 1'b0;
        d_accept   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_W;
                    col_next   = '0;
                    cnt_next   = vec_count;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    load_next[col_reg] = 1'b1;
                    wout_next          = w_data;
                    col_next           = col_reg + 1'b1;
                    if (col_reg == LAST_COL) begin
                        col_next   = '0;
                        state_next = (cnt_reg != '0) ? STREAM : FLUSH;
                    end
                end
            end
            STREAM: begin
                d_ready  = 1'b1;
                d_accept = d_valid;
                if (d_valid) begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (col_reg == LAST_COL) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    col_next   = '0;
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row gi: stage-0 register plus gi extra delay registers; shifts every cycle
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        logic [DATA_W-1:0] pipe_data_reg [0:gi];
        logic [gi:0]       pipe_valid_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= gi; k++) begin
                    pipe_data_reg[k] <= '0;
                end
                pipe_valid_reg <= '0;
            end else begin
                pipe_data_reg[0]  <= d_accept ? d_data[gi*DATA_W +: DATA_W] : '0;
                pipe_valid_reg[0] <= d_accept;
                for (int k = 1; k <= gi; k++) begin
                    pipe_data_reg[k]  <= pipe_data_reg[k-1];
                    pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                end
            end
        end

        assign data_out[gi*DATA_W +: DATA_W] = pipe_data_reg[gi];
        assign valid_out[gi]                 = pipe_valid_reg[gi];
    end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            stall_reg <= '0;
        end else if (state_reg == STREAM && !d_valid && stall_reg != '1) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

    assign load_weights = load_reg;
    assign weights_out  = wout_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed scenarios plus randomized tiles
// checked against a cycle-indexed scoreboard of accepted activation vectors.
module tb_systolic_feeder;
    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int VW     = N * DATA_W;
    localparam int MAXC   = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] vec_count = '0;
    logic             w_valid = 1'b0;
    logic             d_valid = 1'b0;
    logic [VW-1:0]    w_data = '0;
    logic [VW-1:0]    d_data = '0;
    logic             w_ready, d_ready, busy, done;
    logic [N-1:0]     load_weights, valid_out;
    logic [VW-1:0]    weights_out, data_out;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    systolic_feeder #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .load_weights(load_weights), .weights_out(weights_out),
        .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rst_mark = 0;

    // Scoreboard: activation vector accepted at clock edge number e
    bit            acc_v [0:MAXC-1];
    logic [VW-1:0] acc_d [0:MAXC-1];

    typedef enum {M_IDLE, M_LOAD, M_STREAM, M_FLUSH} phase_t;
    phase_t           m_phase = M_IDLE;
    int               m_col, m_vleft, m_fleft;
    logic [N-1:0]     exp_load = '0, exp_valid = '0;
    logic [VW-1:0]    exp_wout = '0, exp_data = '0;
    logic             exp_done = 1'b0;
    logic [CNT_W-1:0] exp_stall = '0;

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int r = 0; r < N; r++) v[r*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
        return v;
    endfunction

    // One clock edge; the reference model advances from the inputs seen before the edge
    task automatic tick();
        bit               s  = start;
        bit               wv = w_valid;
        bit               dv = d_valid;
        logic [CNT_W-1:0] vc = vec_count;
        logic [VW-1:0]    wd = w_data;
        logic [VW-1:0]    dd = d_data;
        bit               d_acc = (m_phase == M_STREAM) && dv;
        @(posedge clk);
        #1;
        cyc++;
        acc_v[cyc] = d_acc;
        acc_d[cyc] = dd;
        exp_load   = '0;
        exp_done   = 1'b0;
        case (m_phase)
            M_IDLE: if (s) begin
                m_phase = M_LOAD; m_col = 0; m_vleft = int'(vc); exp_stall = '0;
            end
            M_LOAD: if (wv) begin
                exp_load[m_col] = 1'b1;
                exp_wout = wd;
                m_col++;
                if (m_col == N) begin
                    m_phase = (m_vleft > 0) ? M_STREAM : M_FLUSH;
                    m_fleft = N;
                end
            end
            M_STREAM: begin
                if (!dv && exp_stall != '1) exp_stall++;
                if (dv) begin
                    m_vleft--;
                    if (m_vleft == 0) begin m_phase = M_FLUSH; m_fleft = N; end
                end
            end
            M_FLUSH: begin
                m_fleft--;
                if (m_fleft == 0) begin m_phase = M_IDLE; exp_done = 1'b1; end
            end
        endcase
        exp_data  = '0;
        exp_valid = '0;
        for (int r = 0; r < N; r++) begin
            int e = cyc - r;
            if (e > rst_mark && acc_v[e]) begin
                exp_valid[r] = 1'b1;
                exp_data[r*DATA_W +: DATA_W] = acc_d[e][r*DATA_W +: DATA_W];
            end
        end
    endtask

    task automatic release_reset(int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            cyc++;
            acc_v[cyc] = 1'b0;
        end
        rst = 1'b1;
        rst_mark = cyc;
        m_phase = M_IDLE;
        exp_load = '0; exp_wout = '0; exp_data = '0; exp_valid = '0;
        exp_done = 1'b0; exp_stall = '0;
    endtask

    task automatic begin_tile(int cnt);
        start = 1'b1; vec_count = CNT_W'(cnt);
        tick();
        start = 1'b0; vec_count = CNT_W'($urandom);
        for (int k = 0; k < N; k++) begin
            w_valid = 1'b1; w_data = rand_vec();
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (load_weights !== '0) $display("FAIL reset_load: got %b want 0", load_weights); else n_pass++;
        n_checks++; if (weights_out !== '0) $display("FAIL reset_wout: got %h want 0", weights_out); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL reset_data: got %h want 0", data_out); else n_pass++;
        n_checks++; if (valid_out !== '0) $display("FAIL reset_valid: got %b want 0", valid_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready); else n_pass++;
        n_checks++; if (d_ready !== 1'b0) $display("FAIL reset_d_ready: got %b want 0", d_ready); else n_pass++;
        release_reset(1);
        $display("test_reset: done");
    endtask

    task automatic test_load_weights();
        logic [VW-1:0] want;
        start = 1'b1; vec_count = CNT_W'(2);
        tick();
        start = 1'b0; vec_count = CNT_W'(16'h00ff);
        n_checks++; if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (w_ready !== 1'b1) $display("FAIL load_w_ready: got %b want 1", w_ready); else n_pass++;
        n_checks++; if (d_ready !== 1'b0) $display("FAIL load_d_ready: got %b want 0", d_ready); else n_pass++;
        for (int k = 0; k < N; k++) begin
            want = {N{DATA_W'(k + 1)}};
            w_valid = 1'b1; w_data = want;
            tick();
            n_checks++; if (load_weights !== N'(1 << k)) $display("FAIL load_strobe%0d: got %b want %b", k, load_weights, N'(1 << k)); else n_pass++;
            n_checks++; if (weights_out !== want) $display("FAIL load_wout%0d: got %h want %h", k, weights_out, want); else n_pass++;
        end
        w_valid = 1'b0;
        n_checks++; if (d_ready !== 1'b1) $display("FAIL load_to_stream: got d_ready %b want 1", d_ready); else n_pass++;
        $display("test_load_weights: done");
    endtask

    task automatic test_back_to_back();
        int a1 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            d_valid = (i < 2);
            d_data  = (i == 0) ? 32'h04030201 : 32'h08070605;
            tick();
            n_checks++; if (data_out !== exp_data) $display("FAIL b2b_data c%0d: got %h want %h", cyc - a1, data_out, exp_data); else n_pass++;
            n_checks++; if (valid_out !== exp_valid) $display("FAIL b2b_valid c%0d: got %b want %b", cyc - a1, valid_out, exp_valid); else n_pass++;
            n_checks++; if (done !== (cyc == a1 + 5)) $display("FAIL b2b_done c%0d: got %b want %b", cyc - a1, done, cyc == a1 + 5); else n_pass++;
            n_checks++; if (load_weights !== '0 || weights_out !== 32'h04040404) $display("FAIL b2b_weights_hold: got %b/%h want 0/04040404", load_weights, weights_out); else n_pass++;
            if (cyc == a1) begin
                n_checks++; if (data_out[7:0] !== 8'd1) $display("FAIL b2b_row0_first: got %0d want 1", data_out[7:0]); else n_pass++;
            end
            if (cyc == a1 + 1) begin
                n_checks++; if (data_out[7:0] !== 8'd5) $display("FAIL b2b_row0_second: got %0d want 5", data_out[7:0]); else n_pass++;
            end
            if (cyc == a1 + 3) begin
                n_checks++; if (data_out[31:24] !== 8'd4 || valid_out[3] !== 1'b1) $display("FAIL b2b_row3_first: got %0d/%b want 4/1", data_out[31:24], valid_out[3]); else n_pass++;
            end
            if (cyc == a1 + 4) begin
                n_checks++; if (data_out[31:24] !== 8'd8 || valid_out[3] !== 1'b1) $display("FAIL b2b_row3_second: got %0d/%b want 8/1", data_out[31:24], valid_out[3]); else n_pass++;
            end
        end
        d_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got busy %b want 0", busy); else n_pass++;
        $display("test_back_to_back: done");
    endtask

    task automatic test_bubbles();
        bit got = 1'b0;
        begin_tile(2);
        for (int i = 0; i < 20 && !got; i++) begin
            d_valid = (i == 0 || i == 4); d_data = rand_vec();
            tick();
            n_checks++; if (data_out !== exp_data) $display("FAIL bubble_data: got %h want %h", data_out, exp_data); else n_pass++;
            n_checks++; if (valid_out !== exp_valid) $display("FAIL bubble_valid: got %b want %b", valid_out, exp_valid); else n_pass++;
            n_checks++; if (done !== exp_done) $display("FAIL bubble_done: got %b want %b", done, exp_done); else n_pass++;
            got = exp_done;
        end
        d_valid = 1'b0;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        n_checks++; if (stall_cycles !== CNT_W'(3)) $display("FAIL bubble_stall: got %0d want 3", stall_cycles); else n_pass++;
`endif
        $display("test_bubbles: done");
    endtask

    task automatic test_zero_count();
        int fe;
        start = 1'b1; vec_count = '0;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_valid = 1'b1; w_data = rand_vec();
            n_checks++; if (d_ready !== 1'b0) $display("FAIL zero_d_ready_load: got %b want 0", d_ready); else n_pass++;
            tick();
        end
        w_valid = 1'b0;
        fe = cyc;
        for (int i = 0; i < N + 2; i++) begin
            d_valid = 1'b1; d_data = rand_vec();
            n_checks++; if (d_ready !== 1'b0) $display("FAIL zero_d_ready_flush: got %b want 0", d_ready); else n_pass++;
            tick();
            n_checks++; if (done !== (cyc == fe + N)) $display("FAIL zero_done c%0d: got %b want %b", cyc - fe, done, cyc == fe + N); else n_pass++;
            n_checks++; if (busy !== (cyc < fe + N)) $display("FAIL zero_busy c%0d: got %b want %b", cyc - fe, busy, cyc < fe + N); else n_pass++;
            n_checks++; if (valid_out !== '0) $display("FAIL zero_valid: got %b want 0", valid_out); else n_pass++;
        end
        d_valid = 1'b0;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        n_checks++; if (stall_cycles !== '0) $display("FAIL zero_stall: got %0d want 0", stall_cycles); else n_pass++;
`endif
        $display("test_zero_count: done");
    endtask

    task automatic test_start_ignored();
        int accepts = 0;
        bit got = 1'b0;
        begin_tile(3);
        for (int i = 0; i < 30 && !got; i++) begin
            d_valid = ($urandom_range(0, 3) != 0); d_data = rand_vec();
            start = (i < 3); vec_count = CNT_W'(9);
            if (d_valid && d_ready) accepts++;
            tick();
            n_checks++; if (data_out !== exp_data || valid_out !== exp_valid) $display("FAIL start_ign_skew: got %h/%b want %h/%b", data_out, valid_out, exp_data, exp_valid); else n_pass++;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0; d_valid = 1'b0;
        n_checks++; if (!got) $display("FAIL start_ign_done: got no done want done within 30 cycles"); else n_pass++;
        n_checks++; if (accepts !== 3) $display("FAIL start_ign_count: got %0d accepts want 3", accepts); else n_pass++;
        $display("test_start_ignored: accepts=%0d", accepts);
    endtask

    task automatic test_reset_midtile();
        bit got = 1'b0;
        begin_tile(3);
        d_valid = 1'b1; d_data = rand_vec();
        tick();
        d_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (data_out !== '0 || valid_out !== '0) $display("FAIL midrst_skew: got %h/%b want 0/0", data_out, valid_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (load_weights !== '0 || weights_out !== '0) $display("FAIL midrst_weights: got %b/%h want 0/0", load_weights, weights_out); else n_pass++;
        n_checks++; if (d_ready !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ready_done: got %b/%b want 0/0", d_ready, done); else n_pass++;
        release_reset(3);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_after: got done %b busy %b want 0 0", done, busy); else n_pass++;
        end
        start = 1'b1; vec_count = CNT_W'(1);
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || w_ready !== 1'b1) $display("FAIL midrst_restart: got busy %b w_ready %b want 1 1", busy, w_ready); else n_pass++;
        for (int i = 0; i < 30 && !got; i++) begin
            w_valid = 1'b1; w_data = rand_vec(); d_valid = 1'b1; d_data = rand_vec();
            tick();
            n_checks++; if (data_out !== exp_data || done !== exp_done) $display("FAIL midrst_tile: got %h/%b want %h/%b", data_out, done, exp_data, exp_done); else n_pass++;
            got = exp_done;
        end
        w_valid = 1'b0; d_valid = 1'b0;
        $display("test_reset_midtile: done");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int cnt = $urandom_range(0, 5);
            bit got = 1'b0;
            start = 1'b1; vec_count = CNT_W'(cnt);
            tick();
            start = 1'b0; vec_count = CNT_W'($urandom);
            for (int i = 0; i < 200 && !got; i++) begin
                w_valid = ($urandom_range(0, 1) != 0); w_data = rand_vec();
                d_valid = ($urandom_range(0, 2) != 0); d_data = rand_vec();
                n_checks++; if (w_ready !== (m_phase == M_LOAD) || d_ready !== (m_phase == M_STREAM)) $display("FAIL rnd_ready t%0d: got %b/%b want %b/%b", t, w_ready, d_ready, m_phase == M_LOAD, m_phase == M_STREAM); else n_pass++;
                tick();
                n_checks++; if (load_weights !== exp_load || weights_out !== exp_wout) $display("FAIL rnd_weights t%0d: got %b/%h want %b/%h", t, load_weights, weights_out, exp_load, exp_wout); else n_pass++;
                n_checks++; if (data_out !== exp_data || valid_out !== exp_valid) $display("FAIL rnd_skew t%0d: got %h/%b want %h/%b", t, data_out, valid_out, exp_data, exp_valid); else n_pass++;
                n_checks++; if (busy !== (m_phase != M_IDLE) || done !== exp_done) $display("FAIL rnd_status t%0d: got %b/%b want %b/%b", t, busy, done, m_phase != M_IDLE, exp_done); else n_pass++;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
                n_checks++; if (stall_cycles !== exp_stall) $display("FAIL rnd_stall t%0d: got %0d want %0d", t, stall_cycles, exp_stall); else n_pass++;
`endif
                got = exp_done;
            end
            w_valid = 1'b0; d_valid = 1'b0;
            n_checks++; if (!got) $display("FAIL rnd_timeout t%0d: got no done want done within 200 cycles", t); else n_pass++;
            $display("test_random: tile %0d vec_count=%0d", t, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_weights();
        test_back_to_back();
        test_bubbles();
        test_zero_count();
        test_start_ignored();
        test_reset_midtile();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
